ex_hazard_ctrl: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/ex_hazard_ctrl_lu_detect.sv | 17 +
 rtl/ex_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_ex_hazard_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, hazard-controller state and pipeline control bundle.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_FREEZE = hz_ctrl_t'(7'b0000000);
  localparam hz_ctrl_t CTRL_ADV    = hz_ctrl_t'(7'b1111100);
  localparam hz_ctrl_t CTRL_BRANCH = hz_ctrl_t'(7'b1111111);
  localparam hz_ctrl_t CTRL_LU     = hz_ctrl_t'(7'b0011101);
  localparam hz_ctrl_t CTRL_IMISS  = hz_ctrl_t'(7'b0111110);

endpackage

// File: rtl/ex_hazard_ctrl_lu_detect.sv
// Combinational load-use detector: a load in EX writes a register the ID instruction reads.
module lu_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_wsel,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  input  logic     id_uses_rt,
  output logic     hazard
);

  // $zero is never a real destination, so it can never create a dependency.
  assign hazard = ex_dREN && (ex_wsel != '0) &&
                  ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, dcache-miss freeze, sticky halt.
module ex_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  regbits_t          id_rs,
  input  regbits_t          id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_dREN,
  input  regbits_t          ex_wsel,
  input  logic              ex_taken,
  input  logic              mem_req,
  input  logic              mem_halt,
  input  logic              ihit,
  input  logic              dhit,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              halt,
  output logic [PERF_W-1:0] stall_cycles
);

  hz_state_t         state_q, state_d;
  logic [2:0]        lu_cnt_q, lu_cnt_d;
  logic [PERF_W-1:0] stall_q;
  logic              lu_hazard;
  logic              run_eval;
  hz_ctrl_t          ctrl;

  lu_detect u_lu_detect (
    .ex_dREN    (ex_dREN),
    .ex_wsel    (ex_wsel),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .hazard     (lu_hazard)
  );

  // The dhit cycle of MEM_WAIT is a full RUN cycle, including its next-state choice.
  assign run_eval = (state_q == RUN) || ((state_q == MEM_WAIT) && dhit);

  always_comb begin
    ctrl     = CTRL_FREEZE;
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    if (run_eval) begin
      state_d = RUN;
      if (mem_halt) begin
        state_d = HALTED;
      end else if (mem_req && !dhit) begin
        state_d = MEM_WAIT;
      end else if (ex_taken) begin
        ctrl = CTRL_BRANCH;
      end else if (lu_hazard) begin
        ctrl = CTRL_LU;
        if (LU_BUBBLES > 1) begin
          state_d  = LU_STALL;
          lu_cnt_d = 3'(LU_BUBBLES - 1);
        end
      end else if (!ihit) begin
        ctrl = CTRL_IMISS;
      end else begin
        ctrl = CTRL_ADV;
      end
    end else if (state_q == LU_STALL) begin
      if (mem_halt) begin
        state_d  = HALTED;
        lu_cnt_d = '0;
      end else if (mem_req && !dhit) begin
        state_d  = MEM_WAIT;
        lu_cnt_d = '0;
      end else begin
        ctrl     = CTRL_LU;
        lu_cnt_d = lu_cnt_q - 3'd1;
        if (lu_cnt_q == 3'd1) state_d = RUN;
      end
    end
    if (RST) ctrl = CTRL_FREEZE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= RUN;
      lu_cnt_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      if (!ctrl.pc_en && (state_q != HALTED) && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign idex_en      = ctrl.idex_en;
  assign exmem_en     = ctrl.exmem_en;
  assign memwb_en     = ctrl.memwb_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign halt         = (state_q == HALTED);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: two instances (1 and 3 load-use bubbles) share one stimulus table.
module tb_ex_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [4:0] id_rs = 5'd1, id_rt = 5'd2, ex_wsel = 5'd0;
  logic       id_uses_rt = 1'b0, ex_dREN = 1'b0, ex_taken = 1'b0;
  logic       mem_req = 1'b0, mem_halt = 1'b0, ihit = 1'b1, dhit = 1'b1;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_iff, a_idf, a_halt;
  logic [31:0] a_stall;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_iff, b_idf, b_halt;
  logic [2:0]  b_stall;

  always #5 CLK = ~CLK;

  ex_hazard_ctrl #(.LU_BUBBLES(1), .PERF_W(32)) dut_a (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .ex_taken(ex_taken), .mem_req(mem_req),
    .mem_halt(mem_halt), .ihit(ihit), .dhit(dhit),
    .pc_en(a_pc), .ifid_en(a_ifid), .idex_en(a_idex), .exmem_en(a_exmem), .memwb_en(a_memwb),
    .ifid_flush(a_iff), .idex_flush(a_idf), .halt(a_halt), .stall_cycles(a_stall)
  );

  ex_hazard_ctrl #(.LU_BUBBLES(3), .PERF_W(3)) dut_b (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .ex_taken(ex_taken), .mem_req(mem_req),
    .mem_halt(mem_halt), .ihit(ihit), .dhit(dhit),
    .pc_en(b_pc), .ifid_en(b_ifid), .idex_en(b_idex), .exmem_en(b_exmem), .memwb_en(b_memwb),
    .ifid_flush(b_iff), .idex_flush(b_idf), .halt(b_halt), .stall_cycles(b_stall)
  );

  // Control vectors {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  localparam logic [6:0] N = 7'b0000000;
  localparam logic [6:0] A = 7'b1111100;
  localparam logic [6:0] L = 7'b0011101;
  localparam logic [6:0] B = 7'b1111111;
  localparam logic [6:0] I = 7'b0111110;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       ur, dr;
    logic [4:0] ws;
    logic       tk, mq, mh, ih, dh;
    logic [6:0] e1, e3;
    logic       hl;
    int unsigned s1, s3;
  } vec_t;

  typedef struct {
    int          idx;
    logic [6:0]  e1, e3;
    logic        hl;
    int unsigned s1, s3;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic add(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                     input logic dr, input logic [4:0] ws, input logic tk, input logic mq,
                     input logic mh, input logic ih, input logic dh, input logic [6:0] e1,
                     input logic [6:0] e3, input logic hl, input int unsigned s1,
                     input int unsigned s3);
    vec_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.ur = ur; v.dr = dr; v.ws = ws;
    v.tk = tk; v.mq = mq; v.mh = mh; v.ih = ih; v.dh = dh;
    v.e1 = e1; v.e3 = e3; v.hl = hl; v.s1 = s1; v.s3 = s3;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0h want %0h", name, idx, act, want);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ctrl_lu1", e.idx, 32'({a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_iff, a_idf}), 32'(e.e1));
      chk("ctrl_lu3", e.idx, 32'({b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_iff, b_idf}), 32'(e.e3));
      chk("halt_lu1", e.idx, 32'(a_halt), 32'(e.hl));
      chk("halt_lu3", e.idx, 32'(b_halt), 32'(e.hl));
      chk("stall_lu1", e.idx, a_stall, e.s1);
      chk("stall_lu3_sat", e.idx, 32'(b_stall), e.s3);
    end
  end

  initial begin
    //  rst rs    rt    ur dr ws    tk mq mh ih dh  e1 e3 hl s1 s3
    add(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, N, N, 0, 0, 0); // 0 reset
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, A, 0, 0, 0);
    add(0, 5'd8, 5'd2, 0, 1, 5'd8, 0, 0, 0, 1, 1, L, L, 0, 0, 0); // 2 load-use on rs
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, L, 0, 1, 1);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, L, 0, 1, 2);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, A, 0, 1, 3);
    add(0, 5'd1, 5'd9, 1, 1, 5'd9, 0, 0, 0, 1, 1, L, L, 0, 1, 3); // 6 load-use on rt
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, L, 0, 2, 4);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, L, 0, 2, 5);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, A, 0, 2, 6);
    add(0, 5'd1, 5'd9, 0, 1, 5'd9, 0, 0, 0, 1, 1, A, A, 0, 2, 6); // 10 rt not used
    add(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 1, 1, A, A, 0, 2, 6); // 11 wsel 0
    add(0, 5'd8, 5'd2, 0, 1, 5'd8, 1, 0, 0, 1, 1, B, B, 0, 2, 6); // 12 branch beats load-use
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, A, 0, 2, 6);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 0, 1, I, I, 0, 2, 6); // 14 icache miss
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, A, 0, 3, 7);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, 1, 0, N, N, 0, 3, 7); // 16 dcache miss x4
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, 1, 0, N, N, 0, 4, 7);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 0, 1, 0, N, N, 0, 5, 7);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, 1, 0, N, N, 0, 6, 7);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, 1, 1, A, A, 0, 7, 7); // 20 dhit
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, A, 0, 7, 7);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, 1, 0, N, N, 0, 7, 7);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, 1, 0, N, N, 0, 8, 7);
    add(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, 1, 0, N, N, 0, 0, 0); // 24 reset mid MEM_WAIT
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, A, 0, 0, 0);
    add(0, 5'd8, 5'd2, 0, 1, 5'd8, 0, 0, 0, 1, 1, L, L, 0, 0, 0);
    add(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, N, N, 0, 0, 0); // 27 reset mid LU_STALL
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, A, 0, 0, 0);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, 1, 1, N, N, 0, 0, 0); // 29 halt
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0, 1, 1, N, N, 1, 1, 1);
    add(0, 5'd8, 5'd2, 0, 1, 5'd8, 1, 0, 0, 0, 1, N, N, 1, 1, 1);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, 1, 1, N, N, 1, 1, 1);
    add(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, N, N, 0, 0, 0);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, A, 0, 0, 0);
    add(0, 5'd8, 5'd2, 0, 1, 5'd8, 0, 0, 0, 1, 1, L, L, 0, 0, 0); // 35 miss preempts LU_STALL
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, 1, 0, N, N, 0, 1, 1);
    add(0, 5'd8, 5'd2, 0, 1, 5'd8, 0, 1, 0, 1, 1, L, L, 0, 2, 2);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, L, 0, 3, 3);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, L, 0, 3, 4);
    add(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 1, A, A, 0, 3, 5);

    #2 RST = 1'b1;
    foreach (vecs[k]) begin
      exp_t e;
      @(posedge CLK);
      #1;
      RST = vecs[k].rst; id_rs = vecs[k].rs; id_rt = vecs[k].rt; id_uses_rt = vecs[k].ur;
      ex_dREN = vecs[k].dr; ex_wsel = vecs[k].ws; ex_taken = vecs[k].tk;
      mem_req = vecs[k].mq; mem_halt = vecs[k].mh; ihit = vecs[k].ih; dhit = vecs[k].dh;
      e.idx = k; e.e1 = vecs[k].e1; e.e3 = vecs[k].e3; e.hl = vecs[k].hl;
      e.s1 = vecs[k].s1; e.s3 = vecs[k].s3;
      sb.push_back(e);
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge CLK);
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
